hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard unit for the pipelined processor: tracks per-register result-ready countdowns and generates stall and flush controls for the fetch, decode and execute boundaries. It extends the fixed load-use/branch checking of the six-stage design to arbitrary per-instruction result latency (loads, multi-cycle ALU ops), a configurable redirect bubble depth, and saturating stall/flush event counters. It sits beside the decode stage; its inputs come from the D→E boundary and the EX branch resolution.

## Interface
- NREG, 32: architectural register count; register 0 is hardwired zero.
- AW, $clog2(NREG): register address width.
- LW, 3: width of the latency field; maximum latency 2^LW−1.
- REDIR_BUBBLES, 1: cycles flush_d stays asserted per redirect (1..2^LW−1).
- CW, 16: event counter width.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- issue_valid  in  1  an instruction crosses D→E this cycle.
- issue_we  in  1  that instruction writes a register.
- issue_rd  in  AW  its destination.
- issue_lat  in  LW  cycles after issue before its result is forwardable (0 = forwardable to the next instruction).
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_rs1, dec_rs2  in  AW  decode source registers.
- dec_use_rs1, dec_use_rs2  in  1  source actually read.
- redirect  in  1  taken branch/jump resolved in EX.
- stall_f, stall_d  out  1  hold PC / hold F→D register.
- flush_d, flush_e  out  1  clear F→D / D→E register (insert bubble).
- pending_mask  out  NREG  bit r = register r has a nonzero timer; bit 0 always 0.
- stall_cnt, flush_cnt  out  CW  saturating counters.

## Operation
- State: timer[r] (LW bits) for r = 1..NREG−1; redirect window counter rw (LW bits); stall_cnt; flush_cnt.
- hazard = dec_valid & rw==0 & ((dec_use_rs1 & dec_rs1!=0 & timer[dec_rs1]!=0) | (same for rs2)).
- Outputs (combinational from state and inputs): flush_d = redirect | rw!=0; flush_e = redirect | hazard; stall_f = stall_d = hazard & !redirect. Redirect always wins over stall.
- Effective issue = issue_valid & issue_we & issue_rd!=0 & !flush_e (a flushed instruction is never recorded).
- Timer update per cycle: non-issued registers decrement if nonzero, saturate at 0. Issued rd: timer ← max(timer−1 saturated, issue_lat) to keep WAW with an older longer-latency producer safe.
- rw: on redirect, rw ← REDIR_BUBBLES−1 (new redirect restarts the window); else decrement if nonzero.
- stall_cnt +1 each cycle stall_d=1; flush_cnt +1 each cycle redirect=1; both saturate at 2^CW−1.

## Timing
- Reset (asynchronous assert): all timers, rw, stall_cnt, flush_cnt → 0; pending_mask → 0; while reset is high all four stall/flush outputs are forced 0 regardless of inputs. Release takes effect on the next clk edge.
- Issue at edge t with latency L: timer=L after t; a dependent decode is stalled for exactly L cycles; L=0 gives no stall.
- Stall and redirect in the same cycle: flush_d=flush_e=1, stall_f=stall_d=0, stall_cnt unchanged.
- Hazard masked during the redirect window (decode content is a bubble).
- Reset mid-window or mid-countdown: all pending state discarded, no residual stall after release.

## Structure
- Package hazard_pkg: latency encodings (LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3) and counter saturation helper constant.
- Sub-module hazard_timer: one per register (generate loop 1..NREG−1), holding the countdown and issue-max logic; top holds hazard compare, redirect window, counters.

## Test plan
- Issue rd=5 lat=1, next decode reads rs1=5 → stall_d high exactly 1 cycle, flush_e high same cycle, stall_cnt=1.
- Issue rd=7 lat=3, then rd=7 lat=0 next cycle → timer stays 2 (max rule); reader of x7 stalls 2 cycles.
- Hazard on x5 and redirect same cycle → flush_d=flush_e=1, stall_d=0, issue not recorded (pending_mask[5] unchanged by it).
- REDIR_BUBBLES=2, redirect pulse → flush_d high 2 cycles; second redirect in cycle 2 → flush_d extended to 3 cycles total, flush_cnt=2.
- Issue rd=0 lat=7 and decode reading x0 → no stall, pending_mask=0.
- Reset asserted mid-countdown (timer[9]=4) → pending_mask=0 immediately, no stall after release; CW=4 with 20 stall cycles → stall_cnt=15.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared latency encodings and counter saturation helper for the hazard scoreboard.
package hazard_pkg;
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;
  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/hazard_timer.sv
// hazard_timer: per-register result-ready countdown; an issue keeps the larger of the
// remaining and new latency so an older, longer-latency producer is never forgotten.
module hazard_timer #(
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue,
  input  logic [LW-1:0] lat,
  output logic [LW-1:0] timer
);
  logic [LW-1:0] dec;
  always_comb dec = (timer != '0) ? timer - LW'(1) : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) timer <= '0;
    else timer <= (issue && lat > dec) ? lat : dec;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency scoreboard producing stall/flush controls,
// a redirect bubble window and saturating stall/flush event counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG          = 32,
  parameter int AW            = $clog2(NREG),
  parameter int LW            = 3,
  parameter int REDIR_BUBBLES = 1,
  parameter int CW            = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_rd,
  input  logic [LW-1:0]   issue_lat,
  input  logic            dec_valid,
  input  logic [AW-1:0]   dec_rs1,
  input  logic [AW-1:0]   dec_rs2,
  input  logic            dec_use_rs1,
  input  logic            dec_use_rs2,
  input  logic            redirect,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            flush_e,
  output logic [NREG-1:0] pending_mask,
  output logic [CW-1:0]   stall_cnt,
  output logic [CW-1:0]   flush_cnt
);
  localparam logic [CW-1:0] CNT_MAX = CW'(sat_max(CW));
  logic [LW-1:0] timer [NREG];
  logic [LW-1:0] rw;
  logic          hazard, iss;
  assign timer[0] = '0;
  assign pending_mask[0] = 1'b0;
  genvar r;
  for (r = 1; r < NREG; r++) begin : g_timer
    hazard_timer #(.LW(LW)) u_timer (
      .clk   (clk),
      .reset (reset),
      .issue (iss && issue_rd == AW'(r)),
      .lat   (issue_lat),
      .timer (timer[r])
    );
    assign pending_mask[r] = timer[r] != '0;
  end
  // Decode content during the redirect window is a bubble, so its sources are ignored.
  always_comb begin
    hazard  = dec_valid && rw == '0 &&
              ((dec_use_rs1 && dec_rs1 != '0 && timer[dec_rs1] != '0) ||
               (dec_use_rs2 && dec_rs2 != '0 && timer[dec_rs2] != '0));
    flush_d = !reset && (redirect || rw != '0);
    flush_e = !reset && (redirect || hazard);
    stall_f = !reset && hazard && !redirect;
    stall_d = stall_f;
    iss     = issue_valid && issue_we && issue_rd != '0 && !flush_e;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rw        <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      rw <= redirect ? LW'(REDIR_BUBBLES - 1) : (rw != '0 ? rw - LW'(1) : '0);
      if (stall_d && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CW'(1);
      if (redirect && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CW'(1);
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks on a default instance (a) and a
// REDIR_BUBBLES=2 / CW=4 instance (b) driven by the same stimulus.
module tb_hazard_scoreboard;
  import hazard_pkg::*;
  logic clk = 0, reset;
  logic issue_valid, issue_we, dec_valid, dec_use_rs1, dec_use_rs2, redirect;
  logic [4:0] issue_rd, dec_rs1, dec_rs2;
  logic [2:0] issue_lat;
  logic stall_f_a, stall_d_a, flush_d_a, flush_e_a;
  logic stall_f_b, stall_d_b, flush_d_b, flush_e_b;
  logic [31:0] pend_a, pend_b;
  logic [15:0] scnt_a, fcnt_a;
  logic [3:0]  scnt_b, fcnt_b;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut_a (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1),
    .dec_use_rs2(dec_use_rs2), .redirect(redirect), .stall_f(stall_f_a),
    .stall_d(stall_d_a), .flush_d(flush_d_a), .flush_e(flush_e_a),
    .pending_mask(pend_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

  hazard_scoreboard #(.REDIR_BUBBLES(2), .CW(4)) dut_b (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1),
    .dec_use_rs2(dec_use_rs2), .redirect(redirect), .stall_f(stall_f_b),
    .stall_d(stall_d_b), .flush_d(flush_d_b), .flush_e(flush_e_b),
    .pending_mask(pend_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    issue_valid = 0; issue_we = 0; issue_rd = 0; issue_lat = 0;
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
    redirect = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
    issue_valid = 1; issue_we = 1; issue_rd = rd; issue_lat = lat;
  endtask

  task automatic read_rs1(input logic [4:0] rs);
    dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = rs;
  endtask

  task automatic test_reset;
    reset = 1; idle;
    issue(5, 3); read_rs1(5); redirect = 1;
    #2;
    total++; if ({stall_f_a, stall_d_a, flush_d_a, flush_e_a} !== 4'b0) begin bad++; $display("FAIL reset_ctl_a got=%b exp=0000", {stall_f_a, stall_d_a, flush_d_a, flush_e_a}); end
    total++; if ({stall_f_b, stall_d_b, flush_d_b, flush_e_b} !== 4'b0) begin bad++; $display("FAIL reset_ctl_b got=%b exp=0000", {stall_f_b, stall_d_b, flush_d_b, flush_e_b}); end
    tick;
    total++; if (pend_a !== 32'h0) begin bad++; $display("FAIL reset_pend got=%h exp=0", pend_a); end
    total++; if (scnt_a !== 16'd0 || fcnt_a !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", scnt_a, fcnt_a); end
    idle; reset = 0;
    tick;
  endtask

  task automatic test_load_use;
    issue(5, 3'(LAT_LOAD));
    #1;
    total++; if (stall_d_a !== 1'b0) begin bad++; $display("FAIL lu_pre_stall got=%b exp=0", stall_d_a); end
    tick; idle; read_rs1(5); #1;
    total++; if ({stall_f_a, stall_d_a, flush_e_a, flush_d_a} !== 4'b1110) begin bad++; $display("FAIL lu_stall got=%b exp=1110", {stall_f_a, stall_d_a, flush_e_a, flush_d_a}); end
    total++; if (pend_a !== 32'h20) begin bad++; $display("FAIL lu_pend got=%h exp=20", pend_a); end
    tick; #1;
    total++; if ({stall_d_a, flush_e_a} !== 2'b00) begin bad++; $display("FAIL lu_release got=%b exp=00", {stall_d_a, flush_e_a}); end
    total++; if (scnt_a !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", scnt_a); end
    idle; tick;
  endtask

  task automatic test_waw;
    logic [2:0] seen;
    issue(7, 3'(LAT_MUL)); tick;
    issue(7, 3'(LAT_ALU)); tick;
    idle; dec_valid = 1; dec_use_rs2 = 1; dec_rs2 = 7;
    for (int i = 0; i < 3; i++) begin
      #1; seen[i] = stall_d_a; tick;
    end
    total++; if (seen !== 3'b011) begin bad++; $display("FAIL waw_stalls got=%b exp=011", seen); end
    total++; if (scnt_a !== 16'd3) begin bad++; $display("FAIL waw_cnt got=%0d exp=3", scnt_a); end
    idle; tick;
  endtask

  task automatic test_redirect_vs_stall;
    issue(5, 3'd2); tick;
    idle; read_rs1(5); redirect = 1; issue(6, 3'd3); #1;
    total++; if ({flush_d_a, flush_e_a, stall_d_a, stall_f_a} !== 4'b1100) begin bad++; $display("FAIL rs_ctl got=%b exp=1100", {flush_d_a, flush_e_a, stall_d_a, stall_f_a}); end
    tick;
    total++; if (pend_a !== 32'h20) begin bad++; $display("FAIL rs_pend got=%h exp=20", pend_a); end
    total++; if (scnt_a !== 16'd3 || fcnt_a !== 16'd1) begin bad++; $display("FAIL rs_cnt got=%0d/%0d exp=3/1", scnt_a, fcnt_a); end
    idle; read_rs1(5); #1;
    total++; if ({stall_d_a, flush_d_a} !== 2'b10) begin bad++; $display("FAIL rs_after_a got=%b exp=10", {stall_d_a, flush_d_a}); end
    total++; if ({stall_d_b, flush_d_b} !== 2'b01) begin bad++; $display("FAIL rs_masked_b got=%b exp=01", {stall_d_b, flush_d_b}); end
    tick; idle; tick;
  endtask

  task automatic test_redirect_window;
    logic [3:0] fd;
    redirect = 1; #1; fd[0] = flush_d_b; tick;
    redirect = 1; #1; fd[1] = flush_d_b; tick;
    redirect = 0; #1; fd[2] = flush_d_b; tick;
    #1; fd[3] = flush_d_b;
    total++; if (fd !== 4'b0111) begin bad++; $display("FAIL rw_window got=%b exp=0111", fd); end
    total++; if (fcnt_b !== 4'd3) begin bad++; $display("FAIL rw_fcnt got=%0d exp=3", fcnt_b); end
    tick;
  endtask

  task automatic test_x0;
    issue(0, 3'd7); read_rs1(0); #1;
    total++; if ({stall_d_a, flush_e_a} !== 2'b00) begin bad++; $display("FAIL x0_stall got=%b exp=00", {stall_d_a, flush_e_a}); end
    tick; idle; read_rs1(0); #1;
    total++; if (pend_a !== 32'h0 || stall_d_a !== 1'b0) begin bad++; $display("FAIL x0_pend got=%h/%b exp=0/0", pend_a, stall_d_a); end
    idle; tick;
  endtask

  task automatic test_reset_mid;
    issue(9, 3'd4); tick;
    idle;
    total++; if (pend_a !== 32'h200) begin bad++; $display("FAIL mid_pend got=%h exp=200", pend_a); end
    redirect = 1; tick;
    redirect = 0; read_rs1(9);
    #2; reset = 1; #1;
    total++; if (pend_a !== 32'h0 || pend_b !== 32'h0) begin bad++; $display("FAIL mid_pend_clr got=%h/%h exp=0/0", pend_a, pend_b); end
    total++; if ({stall_d_a, flush_e_a, flush_d_b} !== 3'b000) begin bad++; $display("FAIL mid_ctl got=%b exp=000", {stall_d_a, flush_e_a, flush_d_b}); end
    tick; reset = 0; #1;
    total++; if ({stall_d_a, stall_d_b, flush_d_b} !== 3'b000) begin bad++; $display("FAIL mid_release got=%b exp=000", {stall_d_a, stall_d_b, flush_d_b}); end
    total++; if (scnt_a !== 16'd0 || fcnt_b !== 4'd0) begin bad++; $display("FAIL mid_cnt got=%0d/%0d exp=0/0", scnt_a, fcnt_b); end
    tick; idle; tick;
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 3; k++) begin
      issue(3, k == 2 ? 3'd6 : 3'd7); tick;
      idle; read_rs1(3);
      for (int i = 0; i < (k == 2 ? 6 : 7); i++) tick;
      idle;
    end
    #1;
    total++; if (scnt_b !== 4'd15) begin bad++; $display("FAIL sat_b got=%0d exp=15", scnt_b); end
    total++; if (scnt_a !== 16'd20) begin bad++; $display("FAIL sat_a got=%0d exp=20", scnt_a); end
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_waw;
    test_redirect_vs_stall;
    test_redirect_window;
    test_x0;
    test_reset_mid;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
